// File: rtl/urf_sensor_emulator_pkg.sv
// Shared definitions for the ultrasonic sensor emulator and its driver.
// Optional build macro used by the emulator top: URF_EMU_NOISE_EN.
package urf_sensor_emulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG_HIGH = 3'd1,
        ST_DELAY     = 3'd2,
        ST_ECHO      = 3'd3,
        ST_HOLDOFF   = 3'd4
    } urf_state_e;

    localparam int unsigned URF_MIN_TRIG_US   = 10;
    localparam int unsigned URF_ECHO_DELAY_US = 20;
    localparam int unsigned URF_NO_ECHO_US    = 38000;
    localparam int unsigned URF_HOLDOFF_US    = 1000;
    localparam logic [9:0]  URF_MAX_RANGE_CM  = 10'd400;
    localparam logic [7:0]  URF_LFSR_SEED     = 8'hA5;

    // 58 us per cm as x64 - x4 - x2; 1023 cm still fits in 16 bits
    function automatic logic [15:0] range_to_us(input logic [9:0] range);
        logic [15:0] r;
        r = {6'd0, range};
        return (r << 6) - (r << 2) - (r << 1);
    endfunction

endpackage

// File: rtl/urf_sensor_emulator_sync_edge.sv
// urf_sync_edge: two-flop synchronizer for the trigger pin plus rise/fall
// strobes taken against the previous synchronized value.
module urf_sync_edge (
    input  logic us_clk,
    input  logic resetn,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // synchronizer chain and one-cycle history for edge detection
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/urf_sensor_emulator.sv
// urf_sensor_emulator: HC-SR04-style responder. Validates the trigger width,
// waits the acoustic delay, then drives an echo whose width encodes range_cm.
// Optional echo-width jitter (0..7 us from an 8-bit LFSR): define URF_EMU_NOISE_EN.
//
// state      | meaning
// IDLE       | waiting for a fresh synchronized trigger rise
// TRIG_HIGH  | counting trigger high time
// DELAY      | acoustic delay before the echo rises
// ECHO       | echo pin high for the latched width
// HOLDOFF    | dead time after echo; triggers ignored
module urf_sensor_emulator
    import urf_sensor_emulator_pkg::*;
#(
    parameter int unsigned MIN_TRIG_US   = URF_MIN_TRIG_US,
    parameter int unsigned ECHO_DELAY_US = URF_ECHO_DELAY_US,
    parameter int unsigned NO_ECHO_US    = URF_NO_ECHO_US,
    parameter int unsigned HOLDOFF_US    = URF_HOLDOFF_US
) (
    input  logic       us_clk,
    input  logic       resetn,
    input  logic       urf_trigger_in,
    input  logic [9:0] range_cm,
    output logic       urf_echo_out,
    output logic       busy,
    output logic       trig_error,
    output logic [7:0] echo_count
);

    localparam logic [15:0] MIN_TRIG_CNT = 16'(MIN_TRIG_US);
    localparam logic [15:0] DELAY_LOAD   = 16'(ECHO_DELAY_US - 1);
    localparam logic [15:0] HOLD_LOAD    = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] NO_ECHO_W    = 16'(NO_ECHO_US);

    logic trig_s;
    logic trig_rise;
    logic trig_fall;

    urf_state_e  state_q, state_d;
    logic [15:0] trig_cnt_q, trig_cnt_d;
    logic [15:0] tmr_q, tmr_d;
    logic [15:0] width_q, width_d;
    logic        echo_q, echo_d;
    logic        busy_q, busy_d;
    logic        trig_err_q, trig_err_d;
    logic [7:0]  echo_count_q, echo_count_d;
    logic [15:0] width_base;
    logic [15:0] width_calc;
`ifdef URF_EMU_NOISE_EN
    logic [7:0]  lfsr_q, lfsr_d;
`endif

    urf_sync_edge u_sync (
        .us_clk   (us_clk),
        .resetn   (resetn),
        .async_in (urf_trigger_in),
        .sync_out (trig_s),
        .rise     (trig_rise),
        .fall     (trig_fall)
    );

    // echo width for the range currently on the input, used at the latch point
    always_comb begin
        if ((range_cm == 10'd0) || (range_cm > URF_MAX_RANGE_CM)) begin
            width_base = NO_ECHO_W;
        end else begin
            width_base = range_to_us(range_cm);
        end
`ifdef URF_EMU_NOISE_EN
        width_calc = width_base + {13'd0, lfsr_q[2:0]};
`else
        width_calc = width_base;
`endif
    end

    // next-state and output decode; one down-counter shared by DELAY/ECHO/HOLDOFF
    always_comb begin
        state_d      = state_q;
        trig_cnt_d   = trig_cnt_q;
        tmr_d        = tmr_q;
        width_d      = width_q;
        echo_d       = 1'b0;
        trig_err_d   = 1'b0;
        echo_count_d = echo_count_q;
`ifdef URF_EMU_NOISE_EN
        lfsr_d       = lfsr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (trig_rise) begin
                    state_d    = ST_TRIG_HIGH;
                    trig_cnt_d = 16'd1;
                end
            end
            ST_TRIG_HIGH: begin
                if (trig_fall) begin
                    if (trig_cnt_q >= MIN_TRIG_CNT) begin
                        state_d = ST_DELAY;
                        tmr_d   = DELAY_LOAD;
                        width_d = width_calc;
`ifdef URF_EMU_NOISE_EN
                        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                    end else begin
                        state_d    = ST_IDLE;
                        trig_err_d = 1'b1;
                    end
                end else if (trig_s && (trig_cnt_q != 16'hFFFF)) begin
                    trig_cnt_d = trig_cnt_q + 16'd1;
                end
            end
            ST_DELAY: begin
                if (tmr_q == 16'd0) begin
                    state_d = ST_ECHO;
                    tmr_d   = width_q - 16'd1;
                    echo_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            ST_ECHO: begin
                if (tmr_q == 16'd0) begin
                    state_d      = ST_HOLDOFF;
                    tmr_d        = HOLD_LOAD;
                    echo_count_d = echo_count_q + 8'd1;
                end else begin
                    tmr_d  = tmr_q - 16'd1;
                    echo_d = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (tmr_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // state, timer and registered outputs
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            trig_cnt_q   <= 16'd0;
            tmr_q        <= 16'd0;
            width_q      <= 16'd0;
            echo_q       <= 1'b0;
            busy_q       <= 1'b0;
            trig_err_q   <= 1'b0;
            echo_count_q <= 8'd0;
`ifdef URF_EMU_NOISE_EN
            lfsr_q       <= URF_LFSR_SEED;
`endif
        end else begin
            state_q      <= state_d;
            trig_cnt_q   <= trig_cnt_d;
            tmr_q        <= tmr_d;
            width_q      <= width_d;
            echo_q       <= echo_d;
            busy_q       <= busy_d;
            trig_err_q   <= trig_err_d;
            echo_count_q <= echo_count_d;
`ifdef URF_EMU_NOISE_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    assign urf_echo_out = echo_q;
    assign busy         = busy_q;
    assign trig_error   = trig_err_q;
    assign echo_count   = echo_count_q;

endmodule

// File: tb/tb_urf_sensor_emulator.sv
// Scoreboard bench for urf_sensor_emulator. Holdoff and no-echo widths are
// shortened through parameters to keep run time reasonable.
module tb_urf_sensor_emulator;

    localparam int MIN_TRIG = 10;
    localparam int DELAY    = 20;
    localparam int HOLD     = 16;
    localparam int NOECHO   = 3800;
    localparam int MAXR     = 400;
    localparam int CM_US    = 58;
    localparam int LAT      = 3 + DELAY;

    logic       us_clk = 1'b0;
    logic       resetn = 1'b0;
    logic       urf_trigger_in = 1'b0;
    logic [9:0] range_cm = 10'd0;
    logic       urf_echo_out;
    logic       busy;
    logic       trig_error;
    logic [7:0] echo_count;

    typedef struct {
        int rise;
        int width;
    } echo_t;

    echo_t exp_q[$];
    int    err_q[$];
    echo_t exp_e;
    int    exp_count   = 0;
    int    echoes_seen = 0;
    int    checks      = 0;
    int    errors      = 0;
    int    cyc         = 0;
    bit    jit_seen[8];

    urf_sensor_emulator #(
        .MIN_TRIG_US   (MIN_TRIG),
        .ECHO_DELAY_US (DELAY),
        .NO_ECHO_US    (NOECHO),
        .HOLDOFF_US    (HOLD)
    ) dut (
        .us_clk         (us_clk),
        .resetn         (resetn),
        .urf_trigger_in (urf_trigger_in),
        .range_cm       (range_cm),
        .urf_echo_out   (urf_echo_out),
        .busy           (busy),
        .trig_error     (trig_error),
        .echo_count     (echo_count)
    );

    always #5 us_clk = ~us_clk;
    always @(posedge us_clk) cyc <= cyc + 1;

    function automatic int model_width(input int range);
        if (range == 0 || range > MAXR) return NOECHO;
        return range * CM_US;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // monitor: pops expectations whenever the DUT presents an echo or error
    initial begin : monitor
        bit prev_echo;
        int rise_c;
        int w;
        prev_echo = 1'b0;
        rise_c = 0;
        forever begin
            @(negedge us_clk);
            if (!resetn) begin
                prev_echo = 1'b0;
                continue;
            end
            if (trig_error) begin
                if (err_q.size() == 0) check("unexpected_trig_error", cyc, -1);
                else check("trig_error_cycle", cyc, err_q.pop_front());
            end
            if (urf_echo_out && !prev_echo) begin
                rise_c = cyc;
                check("busy_during_echo", int'(busy), 1);
            end
            if (!urf_echo_out && prev_echo) begin
                echoes_seen++;
                w = cyc - rise_c;
                if (exp_q.size() == 0) begin
                    check("unexpected_echo_at", rise_c, -1);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("echo_rise_cycle", rise_c, exp_e.rise);
`ifdef URF_EMU_NOISE_EN
                    check_range("echo_width", w, exp_e.width, exp_e.width + 7);
                    if (w >= exp_e.width && w <= exp_e.width + 7) jit_seen[w - exp_e.width] = 1'b1;
`else
                    check("echo_width", w, exp_e.width);
`endif
                    exp_count = (exp_count + 1) % 256;
                    check("echo_count", int'(echo_count), exp_count);
                end
            end
            prev_echo = urf_echo_out;
        end
    end

    task automatic pulse(input int width);
        @(negedge us_clk);
        urf_trigger_in = 1'b1;
        repeat (width) @(negedge us_clk);
        urf_trigger_in = 1'b0;
    endtask

    // drive a trigger and push the expected response; range changes after latch
    task automatic trigger(input int width, input int range, output int f);
        @(negedge us_clk);
        range_cm = 10'(range);
        urf_trigger_in = 1'b1;
        repeat (width) @(negedge us_clk);
        urf_trigger_in = 1'b0;
        f = cyc;
        if (width >= MIN_TRIG) exp_q.push_back('{f + LAT, model_width(range)});
        else err_q.push_back(f + 3);
        repeat (5) @(negedge us_clk);
        range_cm = 10'($urandom_range(0, 1023));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge us_clk);
        while (busy && n < budget) begin
            @(negedge us_clk);
            n++;
        end
        check("idle_within_budget", int'(busy), 0);
    endtask

    task automatic measure(input int width, input int range);
        int f;
        trigger(width, range, f);
        wait_idle(30000);
    endtask

    initial begin : watchdog
        #(2_000_000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int f;
        int n0;
        int c0;
        int w;
        int ndist;

        #2;
        check("reset_echo", int'(urf_echo_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_trig_error", int'(trig_error), 0);
        check("reset_echo_count", int'(echo_count), 0);
        repeat (3) @(negedge us_clk);
        resetn = 1'b1;
        repeat (3) @(negedge us_clk);

        // nominal 100 cm, then rejected short triggers
        measure(10, 100);
        check("count_after_first", int'(echo_count), 1);
        n0 = echoes_seen;
        measure(5, 50);
        measure(9, 50);
        check("no_echo_short_trig", echoes_seen, n0);
        check("count_unchanged_short", int'(echo_count), 1);

        // range boundaries
        measure(10, 0);
        measure(10, 401);
        measure(10, 400);
        measure(10, 1);

        // randomized triggers
        for (int i = 0; i < 8; i++) begin
            measure($urandom_range(3, 20), $urandom_range(1, 20));
        end

        // triggers during ECHO and HOLDOFF (the latter held into IDLE) are ignored
        n0 = echoes_seen;
        w = model_width(20);
        trigger(12, 20, f);
        while (cyc < f + LAT + 10) @(negedge us_clk);
        pulse(12);
        while (cyc < f + LAT + w + 1) @(negedge us_clk);
        pulse(40);
        wait_idle(30000);
        check("one_echo_per_accept", echoes_seen - n0, 1);
        measure(10, 7);
        check("rearm_after_holdoff", echoes_seen - n0, 2);

        // reset in the middle of a 5800-cycle echo
        trigger(10, 100, f);
        while (cyc < f + LAT + 3000) @(negedge us_clk);
        @(posedge us_clk);
        #1 resetn = 1'b0;
        #1;
        check("echo_low_in_reset", int'(urf_echo_out), 0);
        check("busy_low_in_reset", int'(busy), 0);
        check("count_zero_in_reset", int'(echo_count), 0);
        exp_q.delete();
        exp_count = 0;
        n0 = echoes_seen;
        repeat (3) @(negedge us_clk);
        resetn = 1'b1;
        repeat (3500) @(negedge us_clk);
        check("no_echo_after_reset", echoes_seen, n0);
        check("idle_after_reset", int'(busy), 0);

        // 256 echoes wrap echo_count back to zero
        c0 = echoes_seen;
        for (int i = 0; i < 256; i++) measure(10, 1);
        check("wrap_echo_total", echoes_seen - c0, 256);
        check("echo_count_wrapped", int'(echo_count), 0);

`ifdef URF_EMU_NOISE_EN
        for (int i = 0; i < 8; i++) jit_seen[i] = 1'b0;
        for (int i = 0; i < 16; i++) measure(10, 1);
        ndist = 0;
        for (int i = 0; i < 8; i++) if (jit_seen[i]) ndist++;
        check("distinct_jitter_ge2", int'(ndist >= 2), 1);
`else
        ndist = 0;
`endif

        repeat (5) @(negedge us_clk);
        check("pending_echoes", exp_q.size(), 0);
        check("pending_errors", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
